mandel_pixel_sched: RTL and testbench
=====================================

# mandel_pixel_sched

Frame-level scheduler for the Mandelbrot engine: walks the screen in groups of four horizontally adjacent pixels and drives `fetch_param` with `i_x`, `i_y`, `zoom_level`, `start` and `rstMBT`. It then waits for the four Mandelbrot (MBT) lanes to finish and writes their four iteration counts to the frame buffer in raster order. It sits between the top-level render control and the `fetch_param` → MBT ×4 datapath.

## Interface
Parameters:
- `H_RES`, 640, pixels per line; must be a multiple of 4
- `V_RES`, 480, lines per frame
- `ITER_W`, 8, width of one lane's iteration count
- `ADDR_W`, 19, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES
- `FETCH_LAT`, 3, cycles for `fetch_param` coordinate outputs to settle after `i_x`/`i_y` change
- `TIMEOUT_CYC`, 4096, watchdog limit per group; used only with the `_EN` macro

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle request to render a frame; ignored while `busy`
- `zoom_in`  in  2  zoom level, sampled on an accepted `frame_start`
- `busy`  out  1  high from an accepted `frame_start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse after the last pixel write
- `i_x`  out  16  x pixel of lane 0 of the current group
- `i_y`  out  16  y pixel of the current group
- `zoom_level`  out  2  latched zoom level, held for the whole frame
- `start`  out  1  one-cycle group start to `fetch_param`
- `rstMBT`  out  1  one-cycle MBT lane reset to `fetch_param`
- `mbt_done`  in  4  per-lane done, level or pulse
- `mbt_iter`  in  4·ITER_W  lane k count at bits [k·ITER_W +: ITER_W]
- `fb_we`  out  1  frame-buffer write strobe
- `fb_addr`  out  ADDR_W  write address
- `fb_data`  out  ITER_W  write data
- `fb_ready`  in  1  frame-buffer accepts the write when `fb_we && fb_ready`

## Operation
- States: IDLE → RST → SETUP → START → WAIT → WRITE → ADVANCE → (RST | DONE) → IDLE.
- IDLE: on `frame_start`:
  - latch `zoom_in` into `zoom_level`
  - clear `i_x`, `i_y` and the address counter
  - go to RST
- RST: `rstMBT`=1 for one cycle; clear the `done_seen[3:0]` and captured-count registers.
- SETUP: hold `i_x`/`i_y` for FETCH_LAT cycles (down-counter).
- START: `start`=1 for one cycle.
- WAIT: on the first cycle lane k shows `mbt_done[k]`=1, set `done_seen[k]` and capture that lane's `mbt_iter` slice.
  - Later changes on that lane are ignored.
  - `mbt_done` seen in IDLE, RST, SETUP or START is ignored.
  - When all four `done_seen` bits are set (including set this cycle) → WRITE.
- WRITE: lane index 0..3; `fb_we`=1, `fb_addr`=counter, `fb_data`=capture[lane].
  - Only on `fb_ready`: the lane index and the counter increment.
  - With `fb_ready` low, `fb_we`, `fb_addr` and `fb_data` are held unchanged.
  - After lane 3 is accepted → ADVANCE.
- ADVANCE:
  - `i_x`+=4. If the new `i_x` == H_RES, then `i_x`=0 and `i_y`+=1.
  - If the group just written was the last one (`i_x`=H_RES−4, `i_y`=V_RES−1) → DONE, else → RST.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Address counter: plain increment, 0 … H_RES·V_RES−1. No multiplier.
- `zoom_in` changes mid-frame have no effect.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - `done_seen` cleared
- Per group, no backpressure: 1 (RST) + FETCH_LAT + 1 (START) + WAIT + 4 (WRITE) + 1 (ADVANCE) cycles.
  - WAIT is at least 1 cycle.
- `start` rises exactly FETCH_LAT+1 cycles after `rstMBT`; the two never overlap.
- `i_x`/`i_y` change only on the ADVANCE→RST edge.
- `frame_done` follows the last accepted write by exactly 2 cycles (ADVANCE, then DONE).
- `rst_n` low mid-frame: all outputs drop asynchronously; the next frame starts only from a new `frame_start`.

## Configuration
- `MANDEL_SCHED_TIMEOUT_EN` defined:
  - A WAIT cycle counter runs.
  - On reaching TIMEOUT_CYC, every lane without `done_seen` is captured as all-ones and the block enters WRITE.
  - Sticky `timeout_flag` output (1 bit, reset 0, cleared on accepted `frame_start`).
- Undefined: no counter, no `timeout_flag` port; WAIT ends only when all four lanes are done.

## Structure
- Shared package `mandel_pkg`:
  - state enum
  - LANES=4 constant
  - zoom-level constants LVL0..LVL3
- Sub-module `sched_lane_capture`: one instance per lane, holding `done_seen` plus the captured count, with clear/capture inputs.
- Sequencing FSM and counters live in the top.

## Test plan
- Bench configuration: H_RES=8, V_RES=2, FETCH_LAT=3, ITER_W=8; MBT model asserts lane k done after 5+k cycles with count 0x10+k.
- Full frame:
  - 4 groups; `i_x`,`i_y` sequence (0,0),(4,0),(0,1),(4,1)
  - 16 writes, addr 0..15, data 0x10..0x13 repeating
  - exactly one `frame_done`, 2 cycles after the write at addr 15
- Backpressure: `fb_ready` low on alternate cycles → same 16 writes, no duplicates or drops; `fb_addr`/`fb_data` stable while stalled.
- Done ordering: lanes finish in order 3,2,1,0 with `mbt_done` as 1-cycle pulses → writes still lane 0..3 with the correct counts.
- Control edges:
  - `frame_start` while busy is ignored
  - `zoom_in` changed mid-frame leaves `zoom_level` at its latched value
  - `rst_n` asserted during WAIT → all outputs 0 at once; no writes until the next `frame_start`
- Timeout (macro on, TIMEOUT_CYC=20): lane 2 never finishes → lane 2 written as 0xFF, `timeout_flag`=1, frame completes.

Source files
------------

// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared state encoding and constants for the Mandelbrot pixel scheduler
package mandel_pkg;

   localparam int LANES = 4;

   localparam logic [1:0] LVL0 = 2'd0;
   localparam logic [1:0] LVL1 = 2'd1;
   localparam logic [1:0] LVL2 = 2'd2;
   localparam logic [1:0] LVL3 = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SETUP,
      S_START,
      S_WAIT,
      S_WRITE,
      S_ADVANCE,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/sched_lane_capture.sv
// rtl/sched_lane_capture.sv - per-lane done flag and iteration count capture
module sched_lane_capture #(
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              cap_en,
   input  logic              force_ones,
   input  logic              done_in,
   input  logic [ITER_W-1:0] iter_in,
   output logic              seen_nxt,
   output logic [ITER_W-1:0] count_nxt
);

   logic              done_seen;
   logic [ITER_W-1:0] count;

   // Next-state values are exported so the scheduler can react to a lane finishing this cycle.
   always_comb begin
      seen_nxt  = done_seen;
      count_nxt = count;
      if (clr) begin
         seen_nxt  = 1'b0;
         count_nxt = '0;
      end else if (cap_en && !done_seen && done_in) begin
         seen_nxt  = 1'b1;
         count_nxt = iter_in;
      end else if (force_ones && !done_seen) begin
         seen_nxt  = 1'b1;
         count_nxt = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_seen <= 1'b0;
         count     <= '0;
      end else begin
         done_seen <= seen_nxt;
         count     <= count_nxt;
      end
   end

endmodule

// File: rtl/mandel_pixel_sched.sv
// rtl/mandel_pixel_sched.sv - frame scheduler walking 4-pixel groups through fetch_param/MBT lanes
// Optional WAIT watchdog and timeout_flag port enabled by MANDEL_SCHED_TIMEOUT_EN.
module mandel_pixel_sched
   import mandel_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int ITER_W      = 8,
   parameter int ADDR_W      = 19,
   parameter int FETCH_LAT   = 3,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic [1:0]              zoom_in,
   output logic                    busy,
   output logic                    frame_done,
   output logic [15:0]             i_x,
   output logic [15:0]             i_y,
   output logic [1:0]              zoom_level,
   output logic                    start,
   output logic                    rstMBT,
   input  logic [LANES-1:0]        mbt_done,
   input  logic [LANES*ITER_W-1:0] mbt_iter,
   output logic                    fb_we,
   output logic [ADDR_W-1:0]       fb_addr,
   output logic [ITER_W-1:0]       fb_data,
   input  logic                    fb_ready
`ifdef MANDEL_SCHED_TIMEOUT_EN
   ,
   output logic                    timeout_flag
`endif
);

   localparam logic [15:0] X_LAST     = 16'(H_RES - 4);
   localparam logic [15:0] Y_LAST     = 16'(V_RES - 1);
   localparam logic [15:0] SETUP_LOAD = 16'(FETCH_LAT - 1);

   sched_state_t      state;
   logic [15:0]       setup_cnt;
   logic [1:0]        lane_idx;
   logic [LANES-1:0]  seen_nxt;
   logic [ITER_W-1:0] cnt_nxt [LANES];
   logic              lane_clr;
   logic              lane_cap;
   logic              lane_force;
   logic              all_seen;

   assign lane_clr = (state == S_RST);
   assign lane_cap = (state == S_WAIT);
   assign all_seen = &seen_nxt;

`ifdef MANDEL_SCHED_TIMEOUT_EN
   logic [31:0] wait_cnt;
   assign lane_force = lane_cap && (wait_cnt == 32'(TIMEOUT_CYC - 1));
`else
   assign lane_force = 1'b0;
`endif

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sched_lane_capture #(
         .ITER_W(ITER_W)
      ) u_cap (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr       (lane_clr),
         .cap_en    (lane_cap),
         .force_ones(lane_force),
         .done_in   (mbt_done[k]),
         .iter_in   (mbt_iter[k*ITER_W +: ITER_W]),
         .seen_nxt  (seen_nxt[k]),
         .count_nxt (cnt_nxt[k])
      );
   end

   // fb_addr doubles as the raster address counter; it only advances on accepted writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         setup_cnt  <= '0;
         lane_idx   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         i_x        <= '0;
         i_y        <= '0;
         zoom_level <= LVL0;
         start      <= 1'b0;
         rstMBT     <= 1'b0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
`ifdef MANDEL_SCHED_TIMEOUT_EN
         wait_cnt     <= '0;
         timeout_flag <= 1'b0;
`endif
      end else begin
         start      <= 1'b0;
         rstMBT     <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  zoom_level <= zoom_in;
                  i_x        <= '0;
                  i_y        <= '0;
                  fb_addr    <= '0;
                  busy       <= 1'b1;
                  rstMBT     <= 1'b1;
                  state      <= S_RST;
`ifdef MANDEL_SCHED_TIMEOUT_EN
                  timeout_flag <= 1'b0;
`endif
               end
            end
            S_RST: begin
               setup_cnt <= SETUP_LOAD;
               state     <= S_SETUP;
            end
            S_SETUP: begin
               if (setup_cnt == 16'd0) begin
                  start <= 1'b1;
                  state <= S_START;
               end else begin
                  setup_cnt <= setup_cnt - 16'd1;
               end
            end
            S_START: begin
`ifdef MANDEL_SCHED_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
`ifdef MANDEL_SCHED_TIMEOUT_EN
               wait_cnt <= wait_cnt + 32'd1;
               if (lane_force) begin
                  timeout_flag <= 1'b1;
               end
`endif
               if (all_seen) begin
                  lane_idx <= 2'd0;
                  fb_we    <= 1'b1;
                  fb_data  <= cnt_nxt[0];
                  state    <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (fb_ready) begin
                  fb_addr <= fb_addr + ADDR_W'(1);
                  if (lane_idx == 2'd3) begin
                     fb_we <= 1'b0;
                     state <= S_ADVANCE;
                  end else begin
                     lane_idx <= lane_idx + 2'd1;
                     fb_data  <= cnt_nxt[lane_idx + 2'd1];
                  end
               end
            end
            S_ADVANCE: begin
               if ((i_x == X_LAST) && (i_y == Y_LAST)) begin
                  frame_done <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  if (i_x == X_LAST) begin
                     i_x <= '0;
                     i_y <= i_y + 16'd1;
                  end else begin
                     i_x <= i_x + 16'd4;
                  end
                  rstMBT <= 1'b1;
                  state  <= S_RST;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mandel_pixel_sched.sv
// tb/tb_mandel_pixel_sched.sv - self-checking bench with an MBT lane model and raster write scoreboard
module tb_mandel_pixel_sched;

   localparam int H  = 8;
   localparam int V  = 2;
   localparam int FL = 3;
   localparam int IW = 8;
   localparam int AW = 5;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic [1:0]    zoom_in = 2'd0;
   logic          busy, frame_done, start, rstMBT, fb_we;
   logic          fb_ready = 1'b1;
   logic [15:0]   i_x, i_y;
   logic [1:0]    zoom_level;
   logic [3:0]    mbt_done = 4'd0;
   logic [4*IW-1:0] mbt_iter = '0;
   logic [AW-1:0] fb_addr;
   logic [IW-1:0] fb_data;
`ifdef MANDEL_SCHED_TIMEOUT_EN
   logic          timeout_flag;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mandel_pixel_sched #(
      .H_RES(H), .V_RES(V), .ITER_W(IW), .ADDR_W(AW), .FETCH_LAT(FL), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .zoom_in(zoom_in),
      .busy(busy), .frame_done(frame_done), .i_x(i_x), .i_y(i_y),
      .zoom_level(zoom_level), .start(start), .rstMBT(rstMBT),
      .mbt_done(mbt_done), .mbt_iter(mbt_iter),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
`ifdef MANDEL_SCHED_TIMEOUT_EN
      , .timeout_flag(timeout_flag)
`endif
   );

   // Stimulus modes for the lane model and frame-buffer ready driver.
   int ready_mode = 0;
   bit pulse_mode = 0, reverse_mode = 0, rand_mode = 0;
   int never_lane = -1;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: fb_ready = 1'b1;
         1: fb_ready = ~fb_ready;
         default: fb_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // MBT lane model: lane k finishes a fixed or random number of cycles after start.
   int         lane_cnt [4];
   bit         pend [4];
   bit         just_done [4];
   bit         noise = 0;
   logic [7:0] pend_val [4];
   logic [7:0] grp_iter [4][4];
   int         grp_idx = 0;

   always @(posedge clk) begin
      #1;
      if (!rst_n || rstMBT) begin
         mbt_done = 4'd0;
         noise = 0;
         for (int k = 0; k < 4; k++) begin pend[k] = 0; just_done[k] = 0; end
      end else if (start) begin
         for (int k = 0; k < 4; k++) begin
            lane_cnt[k] = rand_mode ? int'($urandom_range(1, 14)) : (reverse_mode ? 5 + (3 - k) : 5 + k);
            pend_val[k] = rand_mode ? 8'($urandom) : 8'(8'h10 + k);
            pend[k] = (k != never_lane);
            just_done[k] = 0;
            grp_iter[grp_idx % 4][k] = pend[k] ? pend_val[k] : 8'hFF;
         end
         grp_idx++;
         mbt_done = rand_mode ? 4'($urandom) : 4'd0;
         noise = rand_mode;
      end else begin
         if (noise) begin mbt_done = 4'd0; noise = 0; end
         for (int k = 0; k < 4; k++) begin
            if (just_done[k]) begin
               mbt_iter[k*IW +: IW] = 8'hEE;
               if (pulse_mode) mbt_done[k] = 1'b0;
               just_done[k] = 0;
            end
            if (pend[k]) begin
               lane_cnt[k]--;
               if (lane_cnt[k] == 0) begin
                  mbt_done[k] = 1'b1;
                  mbt_iter[k*IW +: IW] = pend_val[k];
                  pend[k] = 0;
                  just_done[k] = 1;
               end
            end
         end
      end
   end

   // Observation logs filled mid-cycle.
   logic [AW-1:0] wr_addr [$];
   logic [IW-1:0] wr_data [$];
   int            wr_cyc [$];
   int            fd_q [$];
   int            gap_q [$];
   logic [15:0]   pos_x [$];
   logic [15:0]   pos_y [$];
   int            rst_cyc = 0, stall_viol = 0, overlap = 0;
   bit            stall_prev = 0;
   logic [AW-1:0] stall_addr;
   logic [IW-1:0] stall_data;

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_prev && (!fb_we || fb_addr !== stall_addr || fb_data !== stall_data)) stall_viol++;
         stall_prev = fb_we && !fb_ready;
         stall_addr = fb_addr;
         stall_data = fb_data;
         if (fb_we && fb_ready) begin
            wr_addr.push_back(fb_addr);
            wr_data.push_back(fb_data);
            wr_cyc.push_back(cyc);
         end
         if (frame_done) fd_q.push_back(cyc);
         if (start && rstMBT) overlap++;
         if (rstMBT) rst_cyc = cyc;
         if (start) begin
            pos_x.push_back(i_x);
            pos_y.push_back(i_y);
            gap_q.push_back(cyc - rst_cyc);
         end
      end
   end

   task automatic clear_logs();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); fd_q.delete();
      gap_q.delete(); pos_x.delete(); pos_y.delete();
      stall_viol = 0; overlap = 0; grp_idx = 0; stall_prev = 0;
   endtask

   task automatic run_frame(input logic [1:0] z, output bit ok);
      clear_logs();
      @(posedge clk); #1 frame_start = 1'b1; zoom_in = z;
      @(posedge clk); #1 frame_start = 1'b0;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (frame_done) begin ok = 1; break; end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, frame_done, i_x, i_y, zoom_level, start, rstMBT, fb_we, fb_addr, fb_data} !== '0)
         begin errors++; $display("FAIL reset_outputs: busy=%b we=%b addr=%0h data=%0h", busy, fb_we, fb_addr, fb_data); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, start, rstMBT, fb_we} !== 4'b0) begin errors++; $display("FAIL reset_idle: got %b want 0000", {busy, start, rstMBT, fb_we}); end
   endtask

   task automatic test_full_frame();
      bit ok;
      ready_mode = 0; pulse_mode = 0; reverse_mode = 0; rand_mode = 0; never_lane = -1;
      run_frame(2'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_frame_done: no frame_done within budget"); end
      checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL full_nwrites: got %0d want 16", wr_addr.size()); end
      for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
         checks++; if (wr_addr[i] !== AW'(i)) begin errors++; $display("FAIL full_addr[%0d]: got %0d want %0d", i, wr_addr[i], i); end
         checks++; if (wr_data[i] !== 8'(8'h10 + i % 4)) begin errors++; $display("FAIL full_data[%0d]: got %0h want %0h", i, wr_data[i], 8'h10 + i % 4); end
      end
      checks++; if (pos_x.size() != 4) begin errors++; $display("FAIL full_ngroups: got %0d want 4", pos_x.size()); end
      for (int g = 0; g < pos_x.size() && g < 4; g++) begin
         checks++;
         if (pos_x[g] !== 16'((g * 4) % H) || pos_y[g] !== 16'((g * 4) / H))
            begin errors++; $display("FAIL full_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", g, pos_x[g], pos_y[g], (g * 4) % H, (g * 4) / H); end
         checks++; if (gap_q[g] != FL + 1) begin errors++; $display("FAIL full_start_gap[%0d]: got %0d want %0d", g, gap_q[g], FL + 1); end
      end
      checks++;
      if (fd_q.size() != 1 || wr_cyc.size() != 16 || fd_q[0] != wr_cyc[15] + 2)
         begin errors++; $display("FAIL full_frame_done_timing: pulses=%0d at %0d want one at last_write+2", fd_q.size(), fd_q.size() > 0 ? fd_q[0] : -1); end
      checks++; if (overlap != 0) begin errors++; $display("FAIL full_start_rst_overlap: got %0d want 0", overlap); end
      checks++; if (busy !== 1'b0 || zoom_level !== 2'd1) begin errors++; $display("FAIL full_end_state: busy=%b zoom=%0d want 0,1", busy, zoom_level); end
   endtask

   task automatic test_backpressure();
      bit ok;
      ready_mode = 1; pulse_mode = 0; reverse_mode = 0; rand_mode = 0; never_lane = -1;
      run_frame(2'd2, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_frame_done: no frame_done within budget"); end
      checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL bp_nwrites: got %0d want 16", wr_addr.size()); end
      for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
         checks++;
         if (wr_addr[i] !== AW'(i) || wr_data[i] !== grp_iter[i / 4][i % 4])
            begin errors++; $display("FAIL bp_write[%0d]: got %0d/%0h want %0d/%0h", i, wr_addr[i], wr_data[i], i, grp_iter[i / 4][i % 4]); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_viol); end
      ready_mode = 0;
   endtask

   task automatic test_done_order();
      bit ok;
      ready_mode = 0; pulse_mode = 1; reverse_mode = 1; rand_mode = 0; never_lane = -1;
      run_frame(2'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL order_frame_done: no frame_done within budget"); end
      checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL order_nwrites: got %0d want 16", wr_addr.size()); end
      for (int i = 0; i < wr_data.size() && i < 16; i++) begin
         checks++; if (wr_data[i] !== 8'(8'h10 + i % 4)) begin errors++; $display("FAIL order_data[%0d]: got %0h want %0h", i, wr_data[i], 8'h10 + i % 4); end
      end
      pulse_mode = 0; reverse_mode = 0;
   endtask

   task automatic test_control();
      bit ok;
      ready_mode = 0; pulse_mode = 0; reverse_mode = 0; rand_mode = 0; never_lane = -1;
      clear_logs();
      @(posedge clk); #1 frame_start = 1'b1; zoom_in = 2'd2;
      @(posedge clk); #1 frame_start = 1'b0;
      repeat (10) @(posedge clk);
      #1 frame_start = 1'b1; zoom_in = 2'd3;
      @(posedge clk); #1 frame_start = 1'b0;
      @(negedge clk);
      checks++; if (zoom_level !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL ctrl_zoom_mid: zoom=%0d busy=%b want 2,1", zoom_level, busy); end
      ok = 0;
      for (int i = 0; i < 3000; i++) begin @(negedge clk); if (frame_done) begin ok = 1; break; end end
      checks++; if (!ok) begin errors++; $display("FAIL ctrl_frame_done: no frame_done within budget"); end
      repeat (60) @(negedge clk);
      checks++; if (wr_addr.size() != 16 || fd_q.size() != 1) begin errors++; $display("FAIL ctrl_ignored_start: writes=%0d done=%0d want 16,1", wr_addr.size(), fd_q.size()); end
      checks++; if (zoom_level !== 2'd2 || busy !== 1'b0) begin errors++; $display("FAIL ctrl_zoom_end: zoom=%0d busy=%b want 2,0", zoom_level, busy); end

      clear_logs();
      @(posedge clk); #1 frame_start = 1'b1; zoom_in = 2'd3;
      @(posedge clk); #1 frame_start = 1'b0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin @(negedge clk); if (start) begin ok = 1; break; end end
      checks++; if (!ok) begin errors++; $display("FAIL ctrl_start_seen: no start within budget"); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, frame_done, i_x, i_y, zoom_level, start, rstMBT, fb_we, fb_addr, fb_data} !== '0)
         begin errors++; $display("FAIL ctrl_async_reset: busy=%b zoom=%0d we=%b want all zero", busy, zoom_level, fb_we); end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (60) @(negedge clk);
      checks++; if (wr_addr.size() != 0 || busy !== 1'b0 || fd_q.size() != 0) begin errors++; $display("FAIL ctrl_after_reset: writes=%0d busy=%b want 0,0", wr_addr.size(), busy); end
   endtask

   task automatic test_random();
      bit ok;
      for (int f = 0; f < 3; f++) begin
         ready_mode = 2; rand_mode = 1; reverse_mode = 0; never_lane = -1;
         pulse_mode = 1'($urandom_range(0, 1));
         run_frame(2'($urandom), ok);
         checks++; if (!ok) begin errors++; $display("FAIL rand_frame_done[%0d]: no frame_done within budget", f); end
         checks++; if (wr_addr.size() != 16 || fd_q.size() != 1) begin errors++; $display("FAIL rand_counts[%0d]: writes=%0d done=%0d want 16,1", f, wr_addr.size(), fd_q.size()); end
         for (int i = 0; i < wr_addr.size() && i < 16; i++) begin
            checks++;
            if (wr_addr[i] !== AW'(i) || wr_data[i] !== grp_iter[i / 4][i % 4])
               begin errors++; $display("FAIL rand_write[%0d.%0d]: got %0d/%0h want %0d/%0h", f, i, wr_addr[i], wr_data[i], i, grp_iter[i / 4][i % 4]); end
         end
         checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_stable[%0d]: got %0d want 0", f, stall_viol); end
      end
      ready_mode = 0; rand_mode = 0; pulse_mode = 0;
   endtask

`ifdef MANDEL_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL to_flag_before: got %b want 0", timeout_flag); end
      ready_mode = 0; pulse_mode = 0; reverse_mode = 0; rand_mode = 0; never_lane = 2;
      run_frame(2'd0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL to_frame_done: no frame_done within budget"); end
      checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL to_nwrites: got %0d want 16", wr_addr.size()); end
      for (int i = 0; i < wr_data.size() && i < 16; i++) begin
         checks++;
         if (wr_data[i] !== ((i % 4 == 2) ? 8'hFF : 8'(8'h10 + i % 4)))
            begin errors++; $display("FAIL to_data[%0d]: got %0h want %0h", i, wr_data[i], (i % 4 == 2) ? 8'hFF : 8'h10 + i % 4); end
      end
      checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag_set: got %b want 1", timeout_flag); end
      never_lane = -1;
      run_frame(2'd0, ok);
      checks++; if (!ok || timeout_flag !== 1'b0) begin errors++; $display("FAIL to_flag_clear: done=%b flag=%b want 1,0", ok, timeout_flag); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_done_order();
      test_control();
      test_random();
`ifdef MANDEL_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
